debug_arbiter: RTL and testbench

Shares the single debug request/response channel (2-bit command, 32-bit data, ack+32-bit response) between two debug requesters, e.g. the JTAG debug port (source 0) and a host/UART debug port (source 1). Runs in the system `clk` domain downstream of the requesters' clock-crossing FIFOs. Requests are accepted round-robin. Up to DEPTH requests may be outstanding. Responses are returned in order to the issuing source. A per-transaction timeout synthesizes a NACK so a hung target cannot wedge either requester.

---
 rtl/debug_pkg.sv | 29 ++
 rtl/debug_tag_fifo.sv | 45 ++++
 rtl/debug_arbiter.sv | 173 +++++++++++++++++
 tb/tb_debug_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared debug channel types: command/data widths, source IDs and the
// request/response field layouts used by the JTAG and host debug paths.
package debug_pkg;

  localparam int unsigned CMD_W  = 2;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] NACK_DATA_DEF = 32'hFFFF_FFFF;

  typedef enum logic {
    SRC_JTAG = 1'b0,
    SRC_HOST = 1'b1
  } src_id_t;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
  } dbg_req_t;

  typedef struct packed {
    logic              ack;
    logic [DATA_W-1:0] data;
  } dbg_resp_t;

  function automatic src_id_t other_src(input src_id_t s);
    return (s == SRC_JTAG) ? SRC_HOST : SRC_JTAG;
  endfunction

endpackage

// File: rtl/debug_tag_fifo.sv
// Synchronous FIFO of source tags with full/empty flags; push and pop may
// occur in the same cycle, including while full.
module debug_tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/debug_arbiter.sv
// Shares one debug request/response channel between two requesters with
// round-robin grant, in-order response return and a per-head timeout NACK.
module debug_arbiter
  import debug_pkg::*;
#(
  parameter int unsigned      DEPTH     = 4,
  parameter int unsigned      TIMEOUT   = 1024,
  parameter logic [31:0]      NACK_DATA = NACK_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s0_req_valid,
  output logic        s0_req_ready,
  input  logic [1:0]  s0_req_bits_cmd,
  input  logic [31:0] s0_req_bits_data,
  output logic        s0_resp_valid,
  input  logic        s0_resp_ready,
  output logic        s0_resp_bits_ack,
  output logic [31:0] s0_resp_bits_data,
  input  logic        s1_req_valid,
  output logic        s1_req_ready,
  input  logic [1:0]  s1_req_bits_cmd,
  input  logic [31:0] s1_req_bits_data,
  output logic        s1_resp_valid,
  input  logic        s1_resp_ready,
  output logic        s1_resp_bits_ack,
  output logic [31:0] s1_resp_bits_data,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [1:0]  m_req_bits_cmd,
  output logic [31:0] m_req_bits_data,
  input  logic        m_resp_valid,
  output logic        m_resp_ready,
  input  logic        m_resp_bits_ack,
  input  logic [31:0] m_resp_bits_data,
  output logic        busy,
  output logic        err_timeout
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Expiry is detected one cycle early so the registered NACK appears
  // exactly TIMEOUT cycles after the head started waiting.
  localparam int unsigned EXP_AT = (TIMEOUT > 1) ? TIMEOUT - 2 : 0;

  src_id_t   rr;
  src_id_t   lock_src;
  src_id_t   grant;
  src_id_t   head_src;
  logic      lock_q;
  logic      lock_hold;
  logic      any_valid;
  logic      req_fire;
  dbg_req_t  req_sel;
  dbg_resp_t resp_out;
  logic      head_resp_valid;
  logic      head_resp_ready;
  logic      trk_full;
  logic      trk_empty;
  logic      trk_pop;
  logic [0:0] trk_head;
  logic [DW-1:0] drop_cnt;
  logic      tout_pend;
  logic [TW-1:0] tcnt;
  logic      counting;
  logic      expire;
  logic      nack_fire;
  logic      drop_fire;

  debug_tag_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (grant),
    .pop       (trk_pop),
    .head      (trk_head),
    .full      (trk_full),
    .empty     (trk_empty)
  );

  assign head_src = src_id_t'(trk_head);
  assign busy     = !trk_empty;

  // The lock only holds while the locked source keeps its request up.
  assign lock_hold = lock_q && ((lock_src == SRC_HOST) ? s1_req_valid : s0_req_valid);

  // Grant: locked source, else round-robin preference, else the lone requester.
  always_comb begin
    grant = SRC_JTAG;
    if (lock_hold)                         grant = lock_src;
    else if (s0_req_valid && s1_req_valid) grant = rr;
    else if (s1_req_valid)                 grant = SRC_HOST;
  end

  // A pop in the same cycle frees a slot, so a full tracker can still accept.
  assign any_valid       = s0_req_valid | s1_req_valid;
  assign m_req_valid     = any_valid & (!trk_full | trk_pop);
  assign req_fire        = m_req_valid & m_req_ready;
  assign req_sel         = (grant == SRC_HOST) ? {s1_req_bits_cmd, s1_req_bits_data}
                                               : {s0_req_bits_cmd, s0_req_bits_data};
  assign m_req_bits_cmd  = m_req_valid ? req_sel.cmd  : '0;
  assign m_req_bits_data = m_req_valid ? req_sel.data : '0;
  assign s0_req_ready    = m_req_ready & m_req_valid & (grant == SRC_JTAG);
  assign s1_req_ready    = m_req_ready & m_req_valid & (grant == SRC_HOST);

  assign head_resp_ready = (head_src == SRC_HOST) ? s1_resp_ready : s0_resp_ready;

  // Response routing: drain dropped/stray responses, synthesize NACK, or pass through.
  always_comb begin
    m_resp_ready    = 1'b1;
    head_resp_valid = 1'b0;
    resp_out        = '0;
    if (drop_cnt == '0 && !trk_empty) begin
      if (tout_pend) begin
        m_resp_ready    = 1'b0;
        head_resp_valid = 1'b1;
        resp_out.ack    = 1'b0;
        resp_out.data   = NACK_DATA;
      end else begin
        m_resp_ready    = head_resp_ready;
        head_resp_valid = m_resp_valid;
        if (m_resp_valid) resp_out = {m_resp_bits_ack, m_resp_bits_data};
      end
    end
  end

  assign s0_resp_valid     = head_resp_valid & (head_src == SRC_JTAG);
  assign s1_resp_valid     = head_resp_valid & (head_src == SRC_HOST);
  assign s0_resp_bits_ack  = s0_resp_valid ? resp_out.ack  : 1'b0;
  assign s0_resp_bits_data = s0_resp_valid ? resp_out.data : '0;
  assign s1_resp_bits_ack  = s1_resp_valid ? resp_out.ack  : 1'b0;
  assign s1_resp_bits_data = s1_resp_valid ? resp_out.data : '0;

  assign trk_pop   = head_resp_valid & head_resp_ready;
  assign nack_fire = tout_pend & trk_pop;
  assign drop_fire = (drop_cnt != '0) & m_resp_valid;
  assign counting  = (TIMEOUT != 0) & !trk_empty & !tout_pend & (drop_cnt == '0);
  assign expire    = counting & (tcnt == TW'(EXP_AT)) & !m_resp_valid;

  // Arbitration state, timeout tracking and late-response drop accounting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr          <= SRC_JTAG;
      lock_q      <= 1'b0;
      lock_src    <= SRC_JTAG;
      drop_cnt    <= '0;
      tout_pend   <= 1'b0;
      tcnt        <= '0;
      err_timeout <= 1'b0;
    end else begin
      lock_q      <= m_req_valid & !m_req_ready;
      lock_src    <= grant;
      err_timeout <= expire;
      if (req_fire) rr <= other_src(grant);
      if (trk_pop) begin
        tcnt <= '0;
      end else if (counting && tcnt != TW'(EXP_AT)) begin
        tcnt <= tcnt + TW'(1);
      end
      if (nack_fire)   tout_pend <= 1'b0;
      else if (expire) tout_pend <= 1'b1;
      if (nack_fire) begin
        if (drop_cnt != DW'(DEPTH)) drop_cnt <= drop_cnt + DW'(1);
      end else if (drop_fire) begin
        drop_cnt <= drop_cnt - DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_debug_arbiter.sv
// Directed bench for debug_arbiter: alternation, grant lock, tracker full,
// timeout NACK with late-response drop, expiry race and mid-flight reset.
`timescale 1ns/1ps
module tb_debug_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_req_valid, s0_req_ready, s0_resp_valid, s0_resp_ready, s0_resp_bits_ack;
  logic [1:0]  s0_req_bits_cmd;
  logic [31:0] s0_req_bits_data, s0_resp_bits_data;
  logic        s1_req_valid, s1_req_ready, s1_resp_valid, s1_resp_ready, s1_resp_bits_ack;
  logic [1:0]  s1_req_bits_cmd;
  logic [31:0] s1_req_bits_data, s1_resp_bits_data;
  logic        m_req_valid, m_req_ready, m_resp_valid, m_resp_ready, m_resp_bits_ack;
  logic [1:0]  m_req_bits_cmd;
  logic [31:0] m_req_bits_data, m_resp_bits_data;
  logic        busy, err_timeout;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  debug_arbiter #(
    .DEPTH     (4),
    .TIMEOUT   (16),
    .NACK_DATA (32'hFFFF_FFFF)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .s0_req_valid      (s0_req_valid),
    .s0_req_ready      (s0_req_ready),
    .s0_req_bits_cmd   (s0_req_bits_cmd),
    .s0_req_bits_data  (s0_req_bits_data),
    .s0_resp_valid     (s0_resp_valid),
    .s0_resp_ready     (s0_resp_ready),
    .s0_resp_bits_ack  (s0_resp_bits_ack),
    .s0_resp_bits_data (s0_resp_bits_data),
    .s1_req_valid      (s1_req_valid),
    .s1_req_ready      (s1_req_ready),
    .s1_req_bits_cmd   (s1_req_bits_cmd),
    .s1_req_bits_data  (s1_req_bits_data),
    .s1_resp_valid     (s1_resp_valid),
    .s1_resp_ready     (s1_resp_ready),
    .s1_resp_bits_ack  (s1_resp_bits_ack),
    .s1_resp_bits_data (s1_resp_bits_data),
    .m_req_valid       (m_req_valid),
    .m_req_ready       (m_req_ready),
    .m_req_bits_cmd    (m_req_bits_cmd),
    .m_req_bits_data   (m_req_bits_data),
    .m_resp_valid      (m_resp_valid),
    .m_resp_ready      (m_resp_ready),
    .m_resp_bits_ack   (m_resp_bits_ack),
    .m_resp_bits_data  (m_resp_bits_data),
    .busy              (busy),
    .err_timeout       (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic dest, input logic [31:0] data);
    chk({tag, "_s0_valid"}, 32'(s0_resp_valid), 32'(dest == 1'b0));
    chk({tag, "_s1_valid"}, 32'(s1_resp_valid), 32'(dest == 1'b1));
    chk({tag, "_data"}, dest ? s1_resp_bits_data : s0_resp_bits_data, data);
    chk({tag, "_ack"}, 32'(dest ? s1_resp_bits_ack : s0_resp_bits_ack), 32'd1);
  endtask

  initial begin
    logic [31:0] dl [4];
    logic        dd [4];

    reset = 1'b0;
    s0_req_valid = 1'b0; s0_req_bits_cmd = '0; s0_req_bits_data = '0; s0_resp_ready = 1'b1;
    s1_req_valid = 1'b0; s1_req_bits_cmd = '0; s1_req_bits_data = '0; s1_resp_ready = 1'b1;
    m_req_ready = 1'b1; m_resp_valid = 1'b0; m_resp_bits_ack = 1'b0; m_resp_bits_data = '0;

    // Reset values
    repeat (3) next_cycle();
    @(negedge clk);
    chk("rst_m_req_valid", 32'(m_req_valid), 32'd0);
    chk("rst_s0_req_ready", 32'(s0_req_ready), 32'd0);
    chk("rst_s1_req_ready", 32'(s1_req_ready), 32'd0);
    chk("rst_m_resp_ready", 32'(m_resp_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_resp_valid", 32'({s0_resp_valid, s1_resp_valid}), 32'd0);
    chk("rst_m_req_data", m_req_bits_data, 32'd0);
    next_cycle();
    reset = 1'b1;

    // Alternation, starting with s0, until the tracker fills
    s0_req_valid = 1'b1; s0_req_bits_cmd = 2'd1; s0_req_bits_data = 32'hA0;
    s1_req_valid = 1'b1; s1_req_bits_cmd = 2'd2; s1_req_bits_data = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_data", m_req_bits_data, (i % 2 == 1) ? 32'hB1 : 32'hA0);
      chk("alt_cmd", 32'(m_req_bits_cmd), (i % 2 == 1) ? 32'd2 : 32'd1);
      chk("alt_s0_ready", 32'(s0_req_ready), 32'(i % 2 == 0));
      next_cycle();
    end
    @(negedge clk);
    chk("full_m_req_valid", 32'(m_req_valid), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    next_cycle();

    // First response frees a slot; a new request enters in the same cycle
    m_resp_valid = 1'b1; m_resp_bits_ack = 1'b1; m_resp_bits_data = 32'h10;
    @(negedge clk);
    check_resp("alt_resp0", 1'b0, 32'h10);
    chk("full_refill_valid", 32'(m_req_valid), 32'd1);
    chk("full_refill_data", m_req_bits_data, 32'hA0);
    next_cycle();
    s0_req_valid = 1'b0; s1_req_valid = 1'b0;
    dl = '{32'h11, 32'h12, 32'h13, 32'h14};
    dd = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int j = 0; j < 4; j++) begin
      m_resp_bits_data = dl[j];
      @(negedge clk);
      check_resp("alt_resp", dd[j], dl[j]);
      next_cycle();
    end
    m_resp_valid = 1'b0;
    @(negedge clk);
    chk("alt_drained_busy", 32'(busy), 32'd0);
    next_cycle();

    // Grant lock: one s1 request first so round-robin now prefers s0
    s1_req_valid = 1'b1; s1_req_bits_cmd = 2'd2; s1_req_bits_data = 32'hB0;
    @(negedge clk);
    chk("lock_pre_data", m_req_bits_data, 32'hB0);
    next_cycle();
    m_req_ready = 1'b0; s1_req_bits_cmd = 2'd3; s1_req_bits_data = 32'hB2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("lock_hold_valid", 32'(m_req_valid), 32'd1);
      chk("lock_hold_data", m_req_bits_data, 32'hB2);
      next_cycle();
    end
    s0_req_valid = 1'b1; s0_req_bits_cmd = 2'd0; s0_req_bits_data = 32'hA3;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("lock_contend_data", m_req_bits_data, 32'hB2);
      chk("lock_contend_cmd", 32'(m_req_bits_cmd), 32'd3);
      next_cycle();
    end
    m_req_ready = 1'b1;
    @(negedge clk);
    chk("lock_fire_data", m_req_bits_data, 32'hB2);
    chk("lock_fire_s1_ready", 32'(s1_req_ready), 32'd1);
    chk("lock_fire_s0_ready", 32'(s0_req_ready), 32'd0);
    next_cycle();
    s1_req_valid = 1'b0;
    @(negedge clk);
    chk("lock_next_data", m_req_bits_data, 32'hA3);
    chk("lock_next_s0_ready", 32'(s0_req_ready), 32'd1);
    next_cycle();
    s0_req_valid = 1'b0;
    m_resp_valid = 1'b1; m_resp_bits_ack = 1'b1;
    dl = '{32'h20, 32'h21, 32'h22, 32'h0};
    dd = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int j = 0; j < 3; j++) begin
      m_resp_bits_data = dl[j];
      @(negedge clk);
      check_resp("lock_resp", dd[j], dl[j]);
      next_cycle();
    end
    m_resp_valid = 1'b0;

    // Timeout: NACK and err pulse 16 cycles after the fire
    s0_req_valid = 1'b1; s0_req_bits_cmd = 2'd1; s0_req_bits_data = 32'hC0;
    @(negedge clk);
    chk("to_fire_data", m_req_bits_data, 32'hC0);
    next_cycle();
    s0_req_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("to_err", 32'(err_timeout), 32'(k == 16));
      chk("to_s0_valid", 32'(s0_resp_valid), 32'(k == 16));
      if (k == 16) begin
        chk("to_nack_ack", 32'(s0_resp_bits_ack), 32'd0);
        chk("to_nack_data", s0_resp_bits_data, 32'hFFFF_FFFF);
        chk("to_m_resp_ready", 32'(m_resp_ready), 32'd0);
      end
      next_cycle();
    end
    @(negedge clk);
    chk("to_err_after", 32'(err_timeout), 32'd0);
    chk("to_busy_after", 32'(busy), 32'd0);
    chk("to_s0_valid_after", 32'(s0_resp_valid), 32'd0);
    next_cycle();
    m_resp_valid = 1'b1; m_resp_bits_ack = 1'b1; m_resp_bits_data = 32'hABCD;
    @(negedge clk);
    chk("drop_m_resp_ready", 32'(m_resp_ready), 32'd1);
    chk("drop_resp_valid", 32'({s0_resp_valid, s1_resp_valid}), 32'd0);
    next_cycle();
    m_resp_valid = 1'b0;

    // Expiry race: real response in the expiry cycle is forwarded
    s1_req_valid = 1'b1; s1_req_bits_cmd = 2'd2; s1_req_bits_data = 32'hD1;
    @(negedge clk);
    chk("race_fire_data", m_req_bits_data, 32'hD1);
    next_cycle();
    s1_req_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      m_resp_valid = (k == 15); m_resp_bits_data = 32'h5A;
      @(negedge clk);
      chk("race_err", 32'(err_timeout), 32'd0);
      chk("race_s1_valid", 32'(s1_resp_valid), 32'(k == 15));
      chk("race_busy", 32'(busy), 32'(k <= 15));
      if (k == 15) chk("race_data", s1_resp_bits_data, 32'h5A);
      next_cycle();
    end
    m_resp_valid = 1'b0;

    // Reset with three requests outstanding
    s0_req_valid = 1'b1; s0_req_bits_data = 32'hA0;
    s1_req_valid = 1'b1; s1_req_bits_data = 32'hB1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_req_data", m_req_bits_data, (i == 1) ? 32'hB1 : 32'hA0);
      next_cycle();
    end
    s0_req_valid = 1'b0; s1_req_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_m_req_valid", 32'(m_req_valid), 32'd0);
    chk("mid_rst_m_resp_ready", 32'(m_resp_ready), 32'd1);
    chk("mid_rst_err", 32'(err_timeout), 32'd0);
    chk("mid_rst_resp_valid", 32'({s0_resp_valid, s1_resp_valid}), 32'd0);
    chk("mid_rst_req_ready", 32'({s0_req_ready, s1_req_ready}), 32'd0);
    next_cycle();
    m_resp_valid = 1'b1; m_resp_bits_ack = 1'b1; m_resp_bits_data = 32'h77;
    @(negedge clk);
    chk("stray_m_resp_ready", 32'(m_resp_ready), 32'd1);
    chk("stray_resp_valid", 32'({s0_resp_valid, s1_resp_valid}), 32'd0);
    next_cycle();
    m_resp_valid = 1'b0;
    s0_req_valid = 1'b1; s1_req_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_rr_data", m_req_bits_data, 32'hA0);
    next_cycle();
    s0_req_valid = 1'b0; s1_req_valid = 1'b0;
    m_resp_valid = 1'b1; m_resp_bits_data = 32'h30;
    @(negedge clk);
    check_resp("post_rst_resp", 1'b0, 32'h30);
    next_cycle();
    m_resp_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
